// File: rtl/regfile_write_ctrl_if.sv
// Write-back request channel from execute into the register file write front end.
interface regfile_write_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
);
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   // Execute side drives requests.
   modport master (
      output wb_valid,
      output wb_addr,
      output wb_data,
      input  wb_ready
   );

   // Write controller accepts requests.
   modport slave (
      input  wb_valid,
      input  wb_addr,
      input  wb_data,
      output wb_ready
   );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Write-side front end for the register file: in-order write-back FIFO that drains one entry
// per cycle onto the RF write port and forwards pending values to read ports A/B.
module regfile_write_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   regfile_write_ctrl_if.slave      wb,
   input  logic                     rf_busy,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_DA,
   output logic [DATA_W-1:0]        rf_D_data,
   input  logic [ADDR_W-1:0]        AA,
   input  logic [ADDR_W-1:0]        BA,
   output logic                     A_fwd_valid,
   output logic [DATA_W-1:0]        A_fwd_data,
   output logic                     B_fwd_valid,
   output logic [DATA_W-1:0]        B_fwd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              enq;
   logic              deq;
   logic              not_empty;

   // Handshake and drain decisions, all from registered occupancy.
   always_comb begin
      not_empty   = (count_q != '0);
      wb.wb_ready = (count_q != CNT_W'(DEPTH));
      enq         = wb.wb_valid && wb.wb_ready;
      deq         = not_empty && !rf_busy;
   end

   // Next-state for pointers, occupancy and per-entry valid bits.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      if (deq) begin
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
         valid_d[rd_ptr_q] = 1'b0;
      end
      if (enq) begin
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         valid_d[wr_ptr_q] = 1'b1;
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards everything queued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // Entry payload storage; contents are qualified by valid_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_ptr_q] <= wb.wb_addr;
         data_q[wr_ptr_q] <= wb.wb_data;
      end
   end

   // Write port: head entry while occupied, zeros otherwise.
   always_comb begin
      rf_we     = deq;
      rf_DA     = not_empty ? addr_q[rd_ptr_q] : '0;
      rf_D_data = not_empty ? data_q[rd_ptr_q] : '0;
      count     = count_q;
   end

   // Forwarding: scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx         = '0;
      A_fwd_valid = 1'b0;
      A_fwd_data  = '0;
      B_fwd_valid = 1'b0;
      B_fwd_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if (valid_q[idx] && (addr_q[idx] == AA)) begin
            A_fwd_valid = 1'b1;
            A_fwd_data  = data_q[idx];
         end
         if (valid_q[idx] && (addr_q[idx] == BA)) begin
            B_fwd_valid = 1'b1;
            B_fwd_data  = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations and a randomized phase.
module tb_regfile_write_ctrl;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DEPTH  = 4;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } entry_t;

   logic              clk;
   logic              reset;
   logic              rf_busy;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_DA;
   logic [DATA_W-1:0] rf_D_data;
   logic [ADDR_W-1:0] AA, BA;
   logic              A_fwd_valid, B_fwd_valid;
   logic [DATA_W-1:0] A_fwd_data, B_fwd_data;
   logic [$clog2(DEPTH):0] count;

   int checks;
   int fails;

   entry_t model_q[$];

   regfile_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

   regfile_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .wb          (wb.slave),
      .rf_busy     (rf_busy),
      .rf_we       (rf_we),
      .rf_DA       (rf_DA),
      .rf_D_data   (rf_D_data),
      .AA          (AA),
      .BA          (BA),
      .A_fwd_valid (A_fwd_valid),
      .A_fwd_data  (A_fwd_data),
      .B_fwd_valid (B_fwd_valid),
      .B_fwd_data  (B_fwd_data),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue; one pop when the RF can take a write, one push when
   // there was room before this edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_q.delete();
      end else begin
         bit do_deq, do_enq;
         entry_t e;
         do_deq = (model_q.size() != 0) && !rf_busy;
         do_enq = wb.wb_valid && (model_q.size() != DEPTH);
         e.a = wb.wb_addr;
         e.d = wb.wb_data;
         if (do_deq) void'(model_q.pop_front());
         if (do_enq) model_q.push_back(e);
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic              ev_a, ev_b;
      logic [DATA_W-1:0] ed_a, ed_b;
      ev_a = 1'b0; ed_a = '0; ev_b = 1'b0; ed_b = '0;
      for (int i = model_q.size() - 1; i >= 0; i--) begin
         if (!ev_a && model_q[i].a == AA) begin ev_a = 1'b1; ed_a = model_q[i].d; end
         if (!ev_b && model_q[i].a == BA) begin ev_b = 1'b1; ed_b = model_q[i].d; end
      end
      chk("count", 32'(count), 32'(model_q.size()));
      chk("wb_ready", 32'(wb.wb_ready), 32'(model_q.size() != DEPTH));
      chk("rf_we", 32'(rf_we), 32'((model_q.size() != 0) && !rf_busy));
      chk("rf_DA", 32'(rf_DA), (model_q.size() != 0) ? 32'(model_q[0].a) : 32'd0);
      chk("rf_D_data", 32'(rf_D_data), (model_q.size() != 0) ? 32'(model_q[0].d) : 32'd0);
      chk("A_fwd_valid", 32'(A_fwd_valid), 32'(ev_a));
      chk("A_fwd_data", 32'(A_fwd_data), 32'(ed_a));
      chk("B_fwd_valid", 32'(B_fwd_valid), 32'(ev_b));
      chk("B_fwd_data", 32'(B_fwd_data), 32'(ed_b));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb.wb_valid = v;
      wb.wb_addr  = a;
      wb.wb_data  = d;
   endtask

   task automatic fill3_then_reset(input string tag);
      rf_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ADDR_W'(k + 4), DATA_W'(16'hA000 + k));
         step();
      end
      drive(1'b0, '0, '0);
      #1 chk({tag, "_count3"}, 32'(count), 32'd3);
      rf_busy = 1'b0;
      #1 chk({tag, "_draining"}, 32'(rf_we), 32'd1);
      reset = 1'b0;
      #1;
      chk({tag, "_rst_we"}, 32'(rf_we), 32'd0);
      chk({tag, "_rst_count"}, 32'(count), 32'd0);
      chk({tag, "_rst_ready"}, 32'(wb.wb_ready), 32'd1);
      chk({tag, "_rst_fwd"}, 32'({A_fwd_valid, B_fwd_valid}), 32'd0);
      step();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk({tag, "_post_rst_we"}, 32'(rf_we), 32'd0);
      end
   endtask

   initial begin
      bit accepted;
      checks = 0;
      fails  = 0;
      reset  = 1'b0;
      rf_busy = 1'b0;
      AA = '0;
      BA = '0;
      drive(1'b0, '0, '0);
      #2;
      chk("reset_ready", 32'(wb.wb_ready), 32'd1);
      chk("reset_count", 32'(count), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();

      // Reset with count=3 clears outputs immediately.
      fill3_then_reset("t1");

      // Single write-back appears on the RF port the cycle after acceptance.
      drive(1'b1, 3'd3, 16'hBEEF);
      step();
      drive(1'b0, '0, '0);
      chk("t2_we", 32'(rf_we), 32'd1);
      chk("t2_DA", 32'(rf_DA), 32'd3);
      chk("t2_data", 32'(rf_D_data), 32'hBEEF);
      step();
      chk("t2_count0", 32'(count), 32'd0);
      chk("t2_we0", 32'(rf_we), 32'd0);

      // Busy RF: four accepted, fifth refused, then in-order drain 1..5 on consecutive cycles.
      rf_busy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, ADDR_W'(k), DATA_W'(k));
         step();
      end
      drive(1'b1, 3'd5, 16'd5);
      chk("t3_full_count", 32'(count), 32'd4);
      chk("t3_full_ready", 32'(wb.wb_ready), 32'd0);
      step();
      chk("t3_still_full", 32'(count), 32'd4);
      rf_busy = 1'b0;
      accepted = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t3_drain_we", 32'(rf_we), 32'd1);
         chk("t3_drain_data", 32'(rf_D_data), 32'(c + 1));
         if (wb.wb_valid && wb.wb_ready) accepted = 1'b1;
         step();
         if (accepted) drive(1'b0, '0, '0);
      end
      chk("t3_empty", 32'(count), 32'd0);

      // Youngest pending value is forwarded; no match gives zeros.
      rf_busy = 1'b1;
      drive(1'b1, 3'd2, 16'h1111);
      step();
      drive(1'b1, 3'd2, 16'h2222);
      step();
      drive(1'b0, '0, '0);
      AA = 3'd2;
      BA = 3'd5;
      #1;
      chk("t4_A_valid", 32'(A_fwd_valid), 32'd1);
      chk("t4_A_data", 32'(A_fwd_data), 32'h2222);
      chk("t4_B_valid", 32'(B_fwd_valid), 32'd0);
      chk("t4_B_data", 32'(B_fwd_data), 32'd0);

      // Simultaneous enqueue and dequeue keeps count; mixed traffic crosses the wrap.
      rf_busy = 1'b0;
      drive(1'b1, 3'd7, 16'h7777);
      step();
      chk("t5_count_hold", 32'(count), 32'd2);
      for (int k = 0; k < 8; k++) begin
         drive(k[0], ADDR_W'(k), DATA_W'(16'h5000 + k));
         rf_busy = (k % 3 == 2);
         step();
      end
      drive(1'b0, '0, '0);
      rf_busy = 1'b0;
      for (int k = 0; k < 6; k++) step();
      chk("t5_drained", 32'(count), 32'd0);

      // Reset mid-drain.
      fill3_then_reset("t6");

      // Randomized traffic with varying back-pressure.
      for (int k = 0; k < 600; k++) begin
         int busy_pct;
         busy_pct = (k < 200) ? 20 : (k < 400) ? 70 : 40;
         drive(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
         rf_busy = ($urandom_range(0, 99) < busy_pct);
         AA = ADDR_W'($urandom);
         BA = ADDR_W'($urandom);
         step();
      end
      drive(1'b0, '0, '0);
      rf_busy = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk("final_empty", 32'(count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
